// File: rtl/square_redraw_scheduler.sv
// ---------------------------------------------------------------------------
// square_redraw_scheduler
//
// Purpose:
//   Schedules pixel-address rasters for an LCD board display. The display is
//   an LCD_WIDTH x LCD_HEIGHT screen. Below a BANNER_HEIGHT clock banner sits
//   an 8x8 board of SQUARE_SIZE squares.
//   - Single squares are requested through a 64-bit dirty mask. The next
//     square to draw is picked round-robin, starting after the square that
//     was served last.
//   - A full-screen redraw can be requested. It has priority over squares
//     and discards square requests that are already pending.
//   Each pixel is presented as an (x,y) address. It advances only when the
//   display accepts it with a pixelWrite/pixelReady handshake.
//
// Ports:
//   clock         in   single clock; all state changes on its rising edge
//   resetApp_n    in   synchronous active-low reset
//   squareDirty   in   [63:0] one-cycle per-square redraw requests
//                      (bit n = row n/8, col n%8)
//   frameRequest  in   one-cycle full-screen redraw request
//   pixelReady    in   display accepts the presented pixel
//   pixelWrite    out  a pixel address is being presented
//   xAddr         out  [7:0] pixel x address
//   yAddr         out  [8:0] pixel y address
//   frameActive   out  full-frame pass in progress
//   squareIdx     out  [5:0] square being drawn (valid with squareActive)
//   squareActive  out  single-square pass in progress
//   frameDone     out  one-cycle pulse after the last frame pixel is accepted
//
// Configuration macro:
//   FRAME_ON_RESET_EN  When defined, a full frame is requested automatically
//                      on the first clock edge after reset is released.
// ---------------------------------------------------------------------------
module square_redraw_scheduler #(
  parameter int LCD_WIDTH     = 240,
  parameter int LCD_HEIGHT    = 320,
  parameter int BANNER_HEIGHT = 40,
  parameter int SQUARE_SIZE   = 30
) (
  input  logic        clock,
  input  logic        resetApp_n,
  input  logic [63:0] squareDirty,
  input  logic        frameRequest,
  input  logic        pixelReady,
  output logic        pixelWrite,
  output logic [7:0]  xAddr,
  output logic [8:0]  yAddr,
  output logic        frameActive,
  output logic [5:0]  squareIdx,
  output logic        squareActive,
  output logic        frameDone
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PICK   = 2'd1,
    FRAME  = 2'd2,
    SQUARE = 2'd3
  } state_t;

  localparam logic [7:0] FRAME_X_LAST = 8'(LCD_WIDTH - 1);
  localparam logic [8:0] FRAME_Y_LAST = 9'(LCD_HEIGHT - 1);
  localparam logic [7:0] SQ_SPAN_X    = 8'(SQUARE_SIZE - 1);
  localparam logic [8:0] SQ_SPAN_Y    = 9'(SQUARE_SIZE - 1);

  state_t      r_state, w_state_next;
  logic [63:0] r_mask, w_mask_next;
  logic        r_frame_pend, w_frame_pend_next;
  logic [5:0]  r_last, w_last_next;
  logic [5:0]  r_idx, w_idx_next;
  logic [7:0]  r_x, w_x_next;
  logic [7:0]  r_x_lo, w_x_lo_next;
  logic [7:0]  r_x_hi, w_x_hi_next;
  logic [8:0]  r_y, w_y_next;
  logic [8:0]  r_y_hi, w_y_hi_next;
  logic        r_pixel_write;
  logic        r_frame_active;
  logic        r_square_active;
  logic        r_frame_done, w_frame_done_next;

  // Frame request source: the external pulse, plus the one-shot after reset
  // when auto-frame is enabled.
  logic w_frame_set;
`ifdef FRAME_ON_RESET_EN
  logic r_boot;
  assign w_frame_set = frameRequest | r_boot;
`else
  assign w_frame_set = frameRequest;
`endif

  // Round-robin pick. Rotating the mask right by (last+1) puts the
  // preferred-next square at bit 0. The lowest set bit of the rotated mask
  // is then the offset from that start point, and the sum wraps mod 64.
  logic [5:0]  w_rr_start;
  logic [5:0]  w_rr_offset;
  logic [5:0]  w_pick;
  logic [63:0] w_mask_rot;

  assign w_rr_start = r_last + 6'd1;
  assign w_mask_rot = 64'({r_mask, r_mask} >> w_rr_start);

  always_comb begin
    w_rr_offset = 6'd0;
    for (int i = 63; i >= 0; i--) begin
      if (w_mask_rot[i]) begin
        w_rr_offset = 6'(i);
      end
    end
  end

  assign w_pick = w_rr_start + w_rr_offset;

  // Top-left pixel of the picked square: column = idx[2:0], row = idx[5:3].
  logic [7:0] w_pick_x0;
  logic [8:0] w_pick_y0;
  assign w_pick_x0 = 8'(int'(w_pick[2:0]) * SQUARE_SIZE);
  assign w_pick_y0 = 9'(BANNER_HEIGHT + int'(w_pick[5:3]) * SQUARE_SIZE);

  // One-hot select of the square being drawn. It is used to retire that
  // square's mask bit when the pass finishes.
  logic [63:0] w_sel;
  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_sel
      assign w_sel[gi] = (r_idx == 6'(gi));
    end
  endgenerate

  // Raster position bookkeeping.
  logic w_accept;
  logic w_row_end;
  logic w_last_pix;
  assign w_accept   = r_pixel_write & pixelReady;
  assign w_row_end  = (r_x == r_x_hi);
  assign w_last_pix = w_row_end & (r_y == r_y_hi);

  always_comb begin
    w_state_next      = r_state;
    // New requests are always captured. The branches below only override
    // this where bits must be retired, and even then the same-edge requests
    // are OR-ed back in so that they are never lost.
    w_mask_next       = r_mask | squareDirty;
    w_frame_pend_next = r_frame_pend | w_frame_set;
    w_last_next       = r_last;
    w_idx_next        = r_idx;
    w_x_next          = r_x;
    w_y_next          = r_y;
    w_x_lo_next       = r_x_lo;
    w_x_hi_next       = r_x_hi;
    w_y_hi_next       = r_y_hi;
    w_frame_done_next = 1'b0;

    case (r_state)
      IDLE: begin
        if (r_frame_pend) begin
          // A full frame repaints every square, so pending squares are moot.
          w_state_next      = FRAME;
          w_mask_next       = squareDirty;
          w_frame_pend_next = w_frame_set;
          w_x_next          = 8'd0;
          w_y_next          = 9'd0;
          w_x_lo_next       = 8'd0;
          w_x_hi_next       = FRAME_X_LAST;
          w_y_hi_next       = FRAME_Y_LAST;
        end else if (|r_mask) begin
          w_state_next = PICK;
        end
      end

      PICK: begin
        w_state_next = SQUARE;
        w_idx_next   = w_pick;
        w_last_next  = w_pick;
        w_x_next     = w_pick_x0;
        w_y_next     = w_pick_y0;
        w_x_lo_next  = w_pick_x0;
        w_x_hi_next  = w_pick_x0 + SQ_SPAN_X;
        w_y_hi_next  = w_pick_y0 + SQ_SPAN_Y;
      end

      FRAME, SQUARE: begin
        if (w_accept) begin
          if (w_last_pix) begin
            w_state_next = IDLE;
            if (r_state == FRAME) begin
              w_frame_done_next = 1'b1;
            end else begin
              w_mask_next = (r_mask & ~w_sel) | squareDirty;
            end
          end else if (w_row_end) begin
            w_x_next = r_x_lo;
            w_y_next = r_y + 9'd1;
          end else begin
            w_x_next = r_x + 8'd1;
          end
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetApp_n) begin
      r_state         <= IDLE;
      r_mask          <= '0;
      r_frame_pend    <= 1'b0;
      r_last          <= 6'd63;
      r_idx           <= '0;
      r_x             <= '0;
      r_y             <= '0;
      r_x_lo          <= '0;
      r_x_hi          <= '0;
      r_y_hi          <= '0;
      r_pixel_write   <= 1'b0;
      r_frame_active  <= 1'b0;
      r_square_active <= 1'b0;
      r_frame_done    <= 1'b0;
`ifdef FRAME_ON_RESET_EN
      r_boot          <= 1'b1;
`endif
    end else begin
      r_state         <= w_state_next;
      r_mask          <= w_mask_next;
      r_frame_pend    <= w_frame_pend_next;
      r_last          <= w_last_next;
      r_idx           <= w_idx_next;
      r_x             <= w_x_next;
      r_y             <= w_y_next;
      r_x_lo          <= w_x_lo_next;
      r_x_hi          <= w_x_hi_next;
      r_y_hi          <= w_y_hi_next;
      // Status outputs are registered decodes of the next state. This
      // keeps them aligned with r_state and free of glitches.
      r_pixel_write   <= (w_state_next == FRAME) || (w_state_next == SQUARE);
      r_frame_active  <= (w_state_next == FRAME);
      r_square_active <= (w_state_next == SQUARE);
      r_frame_done    <= w_frame_done_next;
`ifdef FRAME_ON_RESET_EN
      r_boot          <= 1'b0;
`endif
    end
  end

  assign pixelWrite   = r_pixel_write;
  assign xAddr        = r_x;
  assign yAddr        = r_y;
  assign frameActive  = r_frame_active;
  assign squareIdx    = r_idx;
  assign squareActive = r_square_active;
  assign frameDone    = r_frame_done;

endmodule

// File: tb/tb_square_redraw_scheduler.sv
// ---------------------------------------------------------------------------
// tb_square_redraw_scheduler
//
// Purpose:
//   Self-checking bench for square_redraw_scheduler in its default build
//   (no auto-frame after reset).
//   - Square requests come from a table of {bit, first addr, last addr,
//     stall} records.
//   - Expected passes are queued when a request is driven. Each accepted
//     pixel is compared against the raster that the front pass predicts.
//   - Hand-written sequences cover round-robin order, re-dirty on the
//     final-accept edge, frame priority, and reset during a frame.
// ---------------------------------------------------------------------------
module tb_square_redraw_scheduler;

  localparam int W  = 240;
  localparam int H  = 320;
  localparam int BH = 40;
  localparam int SS = 30;

  logic        clock;
  logic        resetApp_n;
  logic [63:0] squareDirty;
  logic        frameRequest;
  logic        pixelReady;
  logic        pixelWrite;
  logic [7:0]  xAddr;
  logic [8:0]  yAddr;
  logic        frameActive;
  logic [5:0]  squareIdx;
  logic        squareActive;
  logic        frameDone;

  square_redraw_scheduler #(
    .LCD_WIDTH    (W),
    .LCD_HEIGHT   (H),
    .BANNER_HEIGHT(BH),
    .SQUARE_SIZE  (SS)
  ) dut (
    .clock       (clock),
    .resetApp_n  (resetApp_n),
    .squareDirty (squareDirty),
    .frameRequest(frameRequest),
    .pixelReady  (pixelReady),
    .pixelWrite  (pixelWrite),
    .xAddr       (xAddr),
    .yAddr       (yAddr),
    .frameActive (frameActive),
    .squareIdx   (squareIdx),
    .squareActive(squareActive),
    .frameDone   (frameDone)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    bit is_frame;
    int idx;
  } pass_t;

  typedef struct {
    int bitn;
    int x0;
    int y0;
    int xl;
    int yl;
    bit stall;
  } vec_t;

  pass_t sb[$];
  vec_t  vecs[3];

  int checks = 0;
  int errors = 0;

  // Per-pass scoreboard state.
  int pix_cnt = 0;
  bit pass_bad = 0;
  int bad_n, bad_x, bad_y, bad_ex, bad_ey;
  int first_x, first_y, last_x, last_y, first_cyc;
  int fd_cnt, pw_cnt, act_cnt;
  bit redirty_armed = 0;
  bit redirty_watch = 0;
  int redirty_end;

  task automatic check_eq(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void exp_addr(input pass_t p, input int n, output int ex, output int ey);
    if (p.is_frame) begin
      ex = n % W;
      ey = n / W;
    end else begin
      ex = (p.idx % 8) * SS + n % SS;
      ey = BH + (p.idx / 8) * SS + n / SS;
    end
  endfunction

  // Called at a negedge where pixelWrite && pixelReady, i.e. the pixel is
  // accepted on the coming rising edge.
  task automatic accept(input int cyc);
    pass_t p;
    int ex, ey, total;
    bit ok;
    p = sb[0];
    exp_addr(p, pix_cnt, ex, ey);
    total = p.is_frame ? W * H : SS * SS;
    ok = (xAddr == ex) && (yAddr == ey) &&
         (p.is_frame ? (frameActive && !squareActive)
                     : (squareActive && !frameActive && squareIdx == p.idx));
    if (!ok && !pass_bad) begin
      pass_bad = 1;
      bad_n = pix_cnt; bad_x = xAddr; bad_y = yAddr; bad_ex = ex; bad_ey = ey;
    end
    if (pix_cnt == 0) begin
      first_x = xAddr; first_y = yAddr; first_cyc = cyc;
      if (redirty_watch) begin
        check_eq("redirty restart gap", cyc - redirty_end, 3);
        redirty_watch = 0;
      end
    end
    last_x = xAddr;
    last_y = yAddr;
    pix_cnt++;
    if (pix_cnt == total) begin
      if (redirty_armed && !p.is_frame && p.idx == 0) begin
        // Re-request square 0 so it lands on its own final-accept edge.
        squareDirty[0] = 1'b1;
        redirty_armed = 0;
        redirty_watch = 1;
        redirty_end = cyc;
        sb.push_back('{1'b0, 0});
      end
      checks++;
      if (pass_bad) begin
        errors++;
        $display("FAIL raster %s %0d: pixel %0d at (%0d,%0d), expected (%0d,%0d)",
                 p.is_frame ? "frame" : "square", p.idx, bad_n, bad_x, bad_y, bad_ex, bad_ey);
      end
      $display("pass %s %0d: %0d pixels, first (%0d,%0d) last (%0d,%0d)",
               p.is_frame ? "frame" : "square", p.idx, total, first_x, first_y, last_x, last_y);
      void'(sb.pop_front());
      pix_cnt = 0;
      pass_bad = 0;
    end
  endtask

  // Steps the clock until every queued pass has been drawn, or until the
  // cycle budget runs out. Optionally stalls at (45,85), or asserts reset
  // once abort_at pixels have been accepted.
  task automatic run_passes(input int budget, input bit do_stall, input int abort_at);
    int cyc = 0;
    bit stall_left = do_stall;
    bit stop = 0;
    while (sb.size() > 0 && !stop && cyc < budget) begin
      @(negedge clock);
      cyc++;
      squareDirty = '0;
      if (frameDone) fd_cnt++;
      if (abort_at > 0 && pix_cnt == abort_at) begin
        resetApp_n = 1'b0;
        stop = 1;
      end else begin
        if (stall_left && pixelWrite && xAddr == 8'd45 && yAddr == 9'd85) begin
          stall_left = 0;
          pixelReady = 1'b0;
          for (int k = 0; k < 7; k++) begin
            @(negedge clock);
            cyc++;
            check_eq("stall hold {pw,x,y}", {pixelWrite, xAddr, yAddr}, {1'b1, 8'd45, 9'd85});
          end
          pixelReady = 1'b1;
        end
        if (pixelWrite && pixelReady) accept(cyc);
      end
    end
    if (abort_at > 0) check_eq("abort point reached", stop, 1);
    else check_eq("passes outstanding", sb.size(), 0);
    if (do_stall) check_eq("stall address reached", stall_left, 0);
    sb.delete();
    pix_cnt = 0;
    pass_bad = 0;
  endtask

  task automatic idle_watch(input int n);
    pw_cnt = 0;
    act_cnt = 0;
    repeat (n) begin
      @(negedge clock);
      if (frameDone) fd_cnt++;
      if (pixelWrite) pw_cnt++;
      if (frameActive || squareActive) act_cnt++;
    end
  endtask

  initial begin
    resetApp_n   = 1'b0;
    squareDirty  = '0;
    frameRequest = 1'b0;
    pixelReady   = 1'b1;

    vecs[0] = '{9,  30, 70,  59,  99,  1'b1};
    vecs[1] = '{27, 90, 130, 119, 159, 1'b0};
    vecs[2] = '{10, 60, 70,  89,  99,  1'b0};

    // Reset state.
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_eq("reset pixelWrite", pixelWrite, 0);
    check_eq("reset xAddr", xAddr, 0);
    check_eq("reset yAddr", yAddr, 0);
    check_eq("reset squareIdx", squareIdx, 0);
    check_eq("reset frameActive", frameActive, 0);
    check_eq("reset squareActive", squareActive, 0);
    check_eq("reset frameDone", frameDone, 0);
    @(posedge clock);
    #1 resetApp_n = 1'b1;
    idle_watch(6);
    check_eq("idle after reset pixelWrite cycles", pw_cnt, 0);

    // Table-driven single-square requests.
    for (int v = 0; v < 3; v++) begin
      @(posedge clock);
      #1;
      squareDirty = 64'd1 << vecs[v].bitn;
      sb.push_back('{1'b0, vecs[v].bitn});
      $display("request square %0d", vecs[v].bitn);
      @(posedge clock);
      #1 squareDirty = '0;
      @(negedge clock);
      check_eq("latency idle pixelWrite", pixelWrite, 0);
      @(negedge clock);
      check_eq("latency pick pixelWrite", pixelWrite, 0);
      run_passes(2000, vecs[v].stall, 0);
      check_eq("first accept cycle", first_cyc, 1);
      check_eq("first x", first_x, vecs[v].x0);
      check_eq("first y", first_y, vecs[v].y0);
      check_eq("last x", last_x, vecs[v].xl);
      check_eq("last y", last_y, vecs[v].yl);
      idle_watch(4);
      check_eq("post-square pixelWrite cycles", pw_cnt, 0);
      check_eq("post-square active cycles", act_cnt, 0);
    end

    // Round-robin: after square 10, square 60 comes before square 3.
    @(posedge clock);
    #1;
    squareDirty = (64'd1 << 3) | (64'd1 << 60);
    sb.push_back('{1'b0, 60});
    sb.push_back('{1'b0, 3});
    $display("request squares 3 and 60");
    @(posedge clock);
    #1 squareDirty = '0;
    run_passes(3000, 0, 0);

    // Re-dirty square 0 on its own final-accept edge.
    redirty_armed = 1;
    @(posedge clock);
    #1 squareDirty = 64'd1;
    sb.push_back('{1'b0, 0});
    $display("request square 0 with re-dirty");
    @(posedge clock);
    #1 squareDirty = '0;
    run_passes(3000, 0, 0);
    check_eq("redirty triggered", redirty_armed, 0);
    idle_watch(4);
    check_eq("post-redirty pixelWrite cycles", pw_cnt, 0);

    // Frame priority: frame and square 5 requested together.
    @(posedge clock);
    #1;
    frameRequest = 1'b1;
    squareDirty = 64'd1 << 5;
    sb.push_back('{1'b1, 0});
    $display("request frame and square 5");
    @(posedge clock);
    #1;
    frameRequest = 1'b0;
    squareDirty = '0;
    fd_cnt = 0;
    run_passes(80000, 0, 0);
    check_eq("frame first x", first_x, 0);
    check_eq("frame first y", first_y, 0);
    check_eq("frame last x", last_x, 239);
    check_eq("frame last y", last_y, 319);
    idle_watch(8);
    check_eq("frameDone pulses", fd_cnt, 1);
    check_eq("square 5 not redrawn", pw_cnt, 0);

    // Reset in the middle of a frame.
    @(posedge clock);
    #1 frameRequest = 1'b1;
    sb.push_back('{1'b1, 0});
    $display("request frame, reset at pixel 1000");
    @(posedge clock);
    #1 frameRequest = 1'b0;
    fd_cnt = 0;
    run_passes(5000, 0, 1000);
    @(negedge clock);
    check_eq("abort pixelWrite", pixelWrite, 0);
    check_eq("abort frameActive", frameActive, 0);
    check_eq("abort xAddr", xAddr, 0);
    @(posedge clock);
    #1 resetApp_n = 1'b1;
    idle_watch(10);
    check_eq("abort frameDone pulses", fd_cnt, 0);
    check_eq("abort pixelWrite cycles", pw_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/square_redraw_scheduler.md
SQUARE_REDRAW_SCHEDULER -- requirements
Module: square_redraw_scheduler

Interface
REQ-001 Parameter LCD_WIDTH, 240, display width in pixels.
REQ-002 Parameter LCD_HEIGHT, 320, display height in pixels.
REQ-003 Parameter BANNER_HEIGHT, 40, height of the top clock banner; the board starts at this y.
REQ-004 Parameter SQUARE_SIZE, 30, square edge in pixels; the board is 8x8 squares.
REQ-005 clock  input  1  single clock; all state changes on its rising edge.
REQ-006 resetApp_n  input  1  reset, synchronous, active-low.
REQ-007 squareDirty  input  64  per-square one-cycle request flags, bit n = square n (row n/8, col n%8).
REQ-008 frameRequest  input  1  one-cycle request for a full-screen redraw.
REQ-009 pixelReady  input  1  display accepts the presented pixel when high together with pixelWrite.
REQ-010 pixelWrite  output  1  a pixel address is presented.
REQ-011 xAddr  output  8  pixel x address.
REQ-012 yAddr  output  9  pixel y address.
REQ-013 frameActive  output  1  high while a full-frame pass is in progress.
REQ-014 squareIdx  output  6  square being drawn; valid while squareActive is high.
REQ-015 squareActive  output  1  high while a single-square pass is in progress.
REQ-016 frameDone  output  1  one-cycle pulse after the last frame pixel is accepted.

Function
REQ-017 FSM states: IDLE, PICK, FRAME, SQUARE.
REQ-018 Each bit of the 64-bit pending mask is set on the edge where its squareDirty bit is high.
REQ-019 A pending frame flag is set on the edge where frameRequest is high.
REQ-020 IDLE: if the pending frame flag is set, go to FRAME. Otherwise, if any mask bit is set, go to PICK. Otherwise stay in IDLE.
REQ-021 A frame request has priority over squares. Entering FRAME clears the frame flag and every mask bit, except bits set on that same edge, which are kept.
REQ-022 PICK lasts exactly one cycle. It selects the first set bit at or after (last served index + 1), mod 64 (round-robin), loads squareIdx, and goes to SQUARE.
REQ-023 The last-served index resets to 63, so square 0 is served first after reset.
REQ-024 FRAME scans x 0..LCD_WIDTH-1 inner and y 0..LCD_HEIGHT-1 outer, giving 76800 accepted pixels.
REQ-025 SQUARE scans a SQUARE_SIZE x SQUARE_SIZE raster at x0 = col*SQUARE_SIZE and y0 = BANNER_HEIGHT + row*SQUARE_SIZE, giving 900 accepted pixels.
REQ-026 Handshake: pixelWrite is high in FRAME and SQUARE; xAddr and yAddr stay stable until the edge where pixelWrite and pixelReady are both high, and advance by one raster position on that edge.
REQ-027 pixelWrite is low in IDLE and PICK.
REQ-028 After the final pixel of a square is accepted, that square's mask bit is cleared, unless squareDirty sets it on the same edge, in which case it stays set.
REQ-029 After the final pixel of a square is accepted, the FSM goes to IDLE.
REQ-030 After the final frame pixel is accepted, frameDone pulses for one cycle and the FSM goes to IDLE.
REQ-031 Requests arriving during FRAME or SQUARE never abort the current pass.
REQ-032 Latency from a single squareDirty pulse in IDLE (cycle N) to pixelWrite high is 3 edges: mask set at N, PICK at N+1, SQUARE at N+2.
REQ-033 frameActive and squareActive are registered decodes of the FRAME and SQUARE states; they are never both high.

Reset
REQ-034 While resetApp_n is low at a clock edge, the block enters IDLE.
REQ-035 At such an edge all outputs are 0: pixelWrite, xAddr, yAddr, squareIdx, frameActive, squareActive and frameDone.
REQ-036 At such an edge the mask and frame flag are cleared and the last-served index is set to 63.
REQ-037 Reset asserted mid-pass abandons the pass with no frameDone pulse; pixelWrite is low from that edge onward.

Configuration
REQ-038 Macro FRAME_ON_RESET_EN defined: the frame flag is set on the first edge with resetApp_n high after reset, so a full frame starts automatically.
REQ-039 Macro FRAME_ON_RESET_EN undefined: after reset the block stays in IDLE until a request arrives.

Verification
REQ-040 Square request: squareDirty bit 9 pulsed in IDLE, pixelReady tied high -> first address (30,70) on edge N+2, last address (59,99), 900 accepts, squareActive then low.
REQ-041 Round-robin: bits 3 and 60 pulsed together after square 10 was served -> 60 drawn before 3.
REQ-042 Frame priority: frameRequest and bit 5 pulsed together -> 76800 accepts, frameDone pulses once, bit 5 is not redrawn afterwards.
REQ-043 Stall: pixelReady low for 7 cycles at address (45,85) -> xAddr and yAddr hold, pixelWrite stays high, no advance.
REQ-044 Re-dirty: bit 0 pulsed on the final-accept edge of square 0 -> square 0 is redrawn immediately after.
REQ-045 Reset mid-frame: resetApp_n low at pixel 1000 -> pixelWrite low, no frameDone pulse; with FRAME_ON_RESET_EN a new frame starts at (0,0).
